// File: rtl/cas_tape_decoder.sv
// Sord M5 CMT OUT decoder: recovers bytes from the FSK pulse train and
// queues them in a first-word-fall-through FIFO for the host-upload logic.
module cas_tape_decoder #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_TICKS  = 1000,
  parameter int unsigned BIT_THRESH = 6667,
  parameter int unsigned GAP_TICKS  = 17780,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce_i,
  input  logic               motor_i,
  input  logic               cas_out_i,
  output logic [7:0]         byte_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [FIFO_AW:0]   count_o,
  output logic               gap_o,
  output logic               frame_err_o,
  output logic               overflow_o
);

  localparam logic [CNT_W-1:0] MinCnt   = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] ThrCnt   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] GapCnt   = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] GapM1    = CNT_W'(GAP_TICKS - 1);
  localparam logic [1:0]       StopLast = 2'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] Depth    = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  // Input synchroniser and rising-edge detect
  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise;

  // Period measurement
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_ok, bit_vld, bit_val, gap_evt;

  // Frame FSM
  state_e     state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] stop_idx_q, stop_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       push_d, ferr_d;

  // Push staging and block tracking
  logic       push_q;
  logic [7:0] pbyte_q;
  logic       pushed_q, pushed_d, pend;
  logic       gap_q, gap_d, ferr_q;

  // FIFO
  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   fcnt_q, fcnt_d;
  logic               ovf_q, ovf_d;
  logic               full, pop, wr_en;

  assign rise = sync_q[1] & ~prev_q;

  // Edges closer than MIN_TICKS to the last accepted edge are glitches.
  assign edge_ok = motor_i & rise & (cnt_q >= MinCnt);
  assign bit_vld = edge_ok & (cnt_q < GapCnt);
  assign bit_val = (cnt_q < ThrCnt);
  // Fires once, on the tick that carries the counter into saturation.
  assign gap_evt = motor_i & ~edge_ok & ce_i & (cnt_q == GapM1);

  // Two-flop synchroniser on the raw CMT level plus edge history
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], cas_out_i};
      prev_q <= sync_q[1];
    end
  end

  // Period counter next state: held at 0 with motor off, cleared on accepted edge
  always_comb begin
    cnt_d = cnt_q;
    if (!motor_i || edge_ok) begin
      cnt_d = '0;
    end else if (ce_i && (cnt_q < GapCnt)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Frame FSM next state: advances only on a classified bit
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    ferr_d     = 1'b0;
    if (!motor_i || gap_evt || (edge_ok && !bit_vld)) begin
      state_d = StIdle;
    end else if (bit_vld) begin
      case (state_q)
        StIdle: begin
          if (!bit_val) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        StData: begin
          shift_d = {bit_val, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d    = StStop;
            stop_idx_d = 2'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        StStop: begin
          if (bit_val) begin
            if (stop_idx_q == StopLast) begin
              push_d  = 1'b1;
              state_d = StIdle;
            end else begin
              stop_idx_d = stop_idx_q + 2'd1;
            end
          end else begin
            // A 0 in the stop slot doubles as the next start bit.
            ferr_d    = 1'b1;
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Gap pulse only for blocks that actually produced bytes
  always_comb begin
    pend     = pushed_q | push_q;
    gap_d    = gap_evt & pend;
    pushed_d = gap_evt ? 1'b0 : pend;
  end

  // FIFO bookkeeping: a push into a full FIFO survives only alongside a pop
  always_comb begin
    pop    = valid_o & ready_i;
    full   = (fcnt_q == Depth);
    wr_en  = push_q & (~full | pop);
    ovf_d  = ovf_q | (push_q & full & ~pop);
    fcnt_d = fcnt_q;
    case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Decoder state registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q      <= '0;
      state_q    <= StIdle;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 2'd0;
      shift_q    <= 8'h00;
      push_q     <= 1'b0;
      pbyte_q    <= 8'h00;
      pushed_q   <= 1'b0;
      gap_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      if (push_d) pbyte_q <= shift_q;
      pushed_q   <= pushed_d;
      gap_q      <= gap_d;
      ferr_q     <= ferr_d;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage, no reset needed: contents only visible through valid pointers
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q] <= pbyte_q;
  end

  assign valid_o     = (fcnt_q != '0);
  assign byte_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o     = fcnt_q;
  assign gap_o       = gap_q;
  assign frame_err_o = ferr_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cas_tape_decoder.sv
// Bench for cas_tape_decoder with tick thresholds scaled down 100x.
module tb_cas_tape_decoder;

  localparam int MinT = 10;
  localparam int Thr  = 67;
  localparam int Gap  = 178;
  localparam int StopBits = 2;
  localparam int Aw   = 4;
  localparam int P1   = 44;  // short period -> 1
  localparam int P0   = 89;  // long period  -> 0

  logic clk = 1'b0, reset = 1'b1, ce_i = 1'b0, motor_i = 1'b0, cas = 1'b0, ready = 1'b0;
  logic [7:0]  byte_o;
  logic        valid_o, gap_o, ferr_o, ovf_o;
  logic [Aw:0] count_o;

  cas_tape_decoder #(
    .CNT_W(16), .MIN_TICKS(MinT), .BIT_THRESH(Thr), .GAP_TICKS(Gap),
    .STOP_BITS(StopBits), .FIFO_AW(Aw)
  ) dut (
    .clk_sys(clk), .reset(reset), .ce_i(ce_i), .motor_i(motor_i), .cas_out_i(cas),
    .byte_o(byte_o), .valid_o(valid_o), .ready_i(ready), .count_o(count_o),
    .gap_o(gap_o), .frame_err_o(ferr_o), .overflow_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int obs_gap = 0, obs_ferr = 0, pops = 0;

  // Reference model: byte-level framing from the bits the bench sends
  logic [7:0] exp_q[$];
  logic [7:0] mbyte = 8'h00;
  int  mph = -1, mstop = 0, exp_gap = 0, exp_ferr = 0;
  bit  msince = 1'b0, mforce = 1'b0, movf = 1'b0;
  int  ce_div = 1, ce_ph = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_push(logic [7:0] b);
    msince = 1'b1;
    if (exp_q.size() < (1 << Aw) || mforce) exp_q.push_back(b);
    else movf = 1'b1;
  endfunction

  function automatic void model_bit(bit b);
    if (mph < 0) begin
      if (!b) begin mph = 0; mbyte = 8'h00; end
    end else if (mph < 8) begin
      mbyte[mph] = b;
      mph++;
      mstop = 0;
    end else if (b) begin
      mstop++;
      if (mstop == StopBits) begin model_push(mbyte); mph = -1; end
    end else begin
      exp_ferr++;
      mph = 0;
      mbyte = 8'h00;
    end
  endfunction

  function automatic void model_gap();
    mph = -1;
    if (msince) exp_gap++;
    msince = 1'b0;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mph = -1;
    msince = 1'b0;
    movf = 1'b0;
  endfunction

  // Tick enable: one tick every ce_div clocks
  initial forever begin
    @(posedge clk); #1;
    ce_ph++;
    if (ce_ph >= ce_div) ce_ph = 0;
    ce_i = (ce_ph == 0);
  end

  // Compare process: pops checked against the model every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (gap_o) obs_gap++;
      if (ferr_o) obs_ferr++;
      chk("valid_vs_count", int'(valid_o), int'(count_o != 0));
      if (valid_o && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%02h, expected no byte", byte_o);
        end else begin
          chk("pop_byte", int'(byte_o), int'(exp_q.pop_front()));
          pops++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ce_i) k++;
    end
    #1;
  endtask

  // One square-wave cycle; the closing rising edge classifies it.
  task automatic send_bit(input bit b, input bit glitch = 1'b0);
    int p = b ? P1 : P0;
    if (glitch) begin
      wait_ticks(2); cas = 1'b0; wait_ticks(2); cas = 1'b1;
      wait_ticks(1); cas = 1'b0; wait_ticks(2); cas = 1'b1;
      wait_ticks(p / 2 - 7);
    end else begin
      wait_ticks(p / 2);
    end
    cas = 1'b0;
    wait_ticks(p - p / 2);
    cas = 1'b1;
    model_bit(b);
  endtask

  task automatic send_data(input logic [7:0] b, input bit glitch = 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && !b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit glitch = 1'b0);
    send_bit(1'b0, glitch);
    send_data(b, glitch);
    for (int i = 0; i < StopBits; i++) send_bit(1'b1);
  endtask

  task automatic begin_block(input int nlead);
    cas = 1'b0;
    wait_ticks(Gap + 20);
    model_gap();
    cas = 1'b1;
    for (int i = 0; i < nlead; i++) send_bit(1'b1);
  endtask

  task automatic end_block();
    wait_ticks(P1 / 2);
    cas = 1'b0;
    wait_ticks(Gap + 20);
    model_gap();
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!valid_o) break;
    end
    @(posedge clk); #1;
    ready = 1'b0;
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_count", int'(count_o), 0);
  endtask

  int g0, f0, p0;

  initial begin
    motor_i = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(count_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_byte", int'(byte_o), 0);
    chk("rst_gap", int'(gap_o), 0);
    chk("rst_ferr", int'(ferr_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Long leader then 0x41
    begin_block(200);
    send_frame(8'h41);
    end_block();
    chk("t1_count", int'(count_o), 1);
    chk("t1_byte", int'(byte_o), 8'h41);
    chk("t1_model", exp_q.size(), 1);
    drain();

    // Three back-to-back bytes with a slower tick enable, live draining
    g0 = obs_gap;
    p0 = pops;
    ce_div = 2;
    ready = 1'b1;
    begin_block(10);
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'hA5);
    end_block();
    ready = 1'b0;
    ce_div = 1;
    chk("t2_gap_pulses", obs_gap - g0, 1);
    chk("t2_pops", pops - p0, 3);
    chk("t2_count", int'(count_o), 0);

    // Bad stop after 0x3C; the long stop becomes the start of 0x5A
    f0 = obs_ferr;
    begin_block(10);
    send_bit(1'b0);
    send_data(8'h3C);
    send_bit(1'b0);
    send_data(8'h5A);
    send_bit(1'b1);
    send_bit(1'b1);
    end_block();
    chk("t3_ferr", obs_ferr - f0, 1);
    chk("t3_count", int'(count_o), 1);
    chk("t3_byte", int'(byte_o), 8'h5A);
    drain();

    // Glitch pulses inside every long bit
    f0 = obs_ferr;
    begin_block(10);
    send_frame(8'h96, 1'b1);
    end_block();
    chk("t4_count", int'(count_o), 1);
    chk("t4_byte", int'(byte_o), 8'h96);
    chk("t4_ferr", obs_ferr - f0, 0);
    drain();

    // Overflow: 17 bytes with ready low, then a push that coincides with a pop
    begin_block(5);
    for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i));
    wait_ticks(10);
    chk("t5_count_full", int'(count_o), 16);
    chk("t5_ovf", int'(ovf_o), 1);
    chk("t5_head", int'(byte_o), 8'h10);
    chk("t5_model_ovf", int'(ovf_o), int'(movf));
    mforce = 1'b1;
    send_frame(8'hE7);
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    mforce = 1'b0;
    @(negedge clk);
    chk("t5_count_after", int'(count_o), 16);
    chk("t5_head_after", int'(byte_o), 8'h11);
    end_block();
    p0 = pops;
    drain();
    chk("t5_drained", pops - p0, 16);

    // Motor dropped after 4 data bits, then a clean 0x55
    begin_block(10);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    wait_ticks(10);
    motor_i = 1'b0;
    mph = -1;
    for (int i = 0; i < 4; i++) begin
      cas = 1'b0; wait_ticks(20); cas = 1'b1; wait_ticks(20);
    end
    cas = 1'b0;
    wait_ticks(50);
    motor_i = 1'b1;
    wait_ticks(Gap + 20);
    model_gap();
    begin_block(10);
    send_frame(8'h55);
    end_block();
    chk("t6_count", int'(count_o), 1);
    chk("t6_byte", int'(byte_o), 8'h55);
    chk("t6_ovf_kept", int'(ovf_o), int'(movf));
    drain();

    // Reset in the middle of a second byte flushes everything
    begin_block(10);
    send_frame(8'hC3);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_ticks(5);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("t7_count", int'(count_o), 0);
    chk("t7_valid", int'(valid_o), 0);
    chk("t7_byte", int'(byte_o), 0);
    chk("t7_ovf", int'(ovf_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    begin_block(10);
    send_frame(8'h99);
    end_block();
    chk("t7_after_count", int'(count_o), 1);
    chk("t7_after_byte", int'(byte_o), 8'h99);
    drain();

    chk("total_gap_pulses", obs_gap, exp_gap);
    chk("total_frame_errs", obs_ferr, exp_ferr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
